// File: rtl/fifo_port_arbiter_if.sv
// Request, grant, strobe and status bundle between the requesters, the issue
// arbiter and the shared FIFO pointer block.
interface fifo_port_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int NW     = 4,
    parameter int NR     = 4
);
    logic [NW-1:0]   wr_req;
    logic [NR-1:0]   rd_req;
    logic            emp;
    logic            full;
    logic            wr;
    logic            rd;
    logic [NW-1:0]   wr_gnt;
    logic [NR-1:0]   rd_gnt;
    logic [ADDR_W:0] level;
    logic            err;

    modport master (
        input  wr_req, rd_req, emp, full,
        output wr, rd, wr_gnt, rd_gnt, level, err
    );

    modport slave (
        output wr_req, rd_req, emp, full,
        input  wr, rd, wr_gnt, rd_gnt, level, err
    );
endinterface

// File: rtl/fifo_port_arbiter.sv
// Issue controller for the shared FIFO: one write or read per cycle, round-robin
// within each class, class alternation under contention, occupancy cross-check.
module fifo_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int NW     = 4,
    parameter int NR     = 4
) (
    input logic clk,
    input logic rst_n,
    fifo_port_arbiter_if.master bus
);

    localparam int WPW = (NW > 1) ? $clog2(NW) : 1;
    localparam int RPW = (NR > 1) ? $clog2(NR) : 1;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE} state_t;
    typedef enum logic {CLS_WR, CLS_RD} cls_t;

    state_t          state, nxt_state;
    cls_t            last_cls;
    logic [WPW-1:0]  wptr, wptr_nxt, widx;
    logic [RPW-1:0]  rptr, rptr_nxt, ridx;
    logic [NW-1:0]   wr_onehot, wr_gnt_q;
    logic [NR-1:0]   rd_onehot, rd_gnt_q;
    logic            wr_found, rd_found;
    logic            wr_elig, rd_elig;
    logic [ADDR_W:0] level_q, committed;
    logic            mismatch, err_q;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wr_found  = 1'b0;
        wr_onehot = '0;
        wptr_nxt  = wptr;
        widx      = '0;
        for (int k = 0; k < NW; k++) begin
            widx = WPW'((int'(wptr) + k) % NW);
            if (!wr_found && bus.wr_req[widx]) begin
                wr_found        = 1'b1;
                wr_onehot[widx] = 1'b1;
                wptr_nxt        = WPW'((int'(wptr) + k + 1) % NW);
            end
        end
    end

    always_comb begin
        rd_found  = 1'b0;
        rd_onehot = '0;
        rptr_nxt  = rptr;
        ridx      = '0;
        for (int k = 0; k < NR; k++) begin
            ridx = RPW'((int'(rptr) + k) % NR);
            if (!rd_found && bus.rd_req[ridx]) begin
                rd_found        = 1'b1;
                rd_onehot[ridx] = 1'b1;
                rptr_nxt        = RPW'((int'(rptr) + k + 1) % NR);
            end
        end
    end

    // Under contention the class not issued last goes next; last_cls holds through IDLE.
    always_comb begin
        wr_elig   = wr_found && (level_q < DEPTH);
        rd_elig   = rd_found && (level_q != '0);
        nxt_state = IDLE;
        if (wr_elig && (!rd_elig || last_cls == CLS_RD))
            nxt_state = WR_ISSUE;
        else if (rd_elig)
            nxt_state = RD_ISSUE;
    end

    // The FIFO applies the op on the strobe one edge later, so its flags trail level_q.
    assign committed = level_q - (ADDR_W+1)'(bus.wr) + (ADDR_W+1)'(bus.rd);
    assign mismatch  = (bus.emp != (committed == '0)) || (bus.full != (committed == DEPTH));

    // NOTE: sequential state is assigned with non-blocking <= only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_cls <= CLS_RD;
            wptr     <= '0;
            rptr     <= '0;
            wr_gnt_q <= '0;
            rd_gnt_q <= '0;
            level_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= nxt_state;
            wr_gnt_q <= '0;
            rd_gnt_q <= '0;
            case (nxt_state)
                WR_ISSUE: begin
                    wr_gnt_q <= wr_onehot;
                    wptr     <= wptr_nxt;
                    last_cls <= CLS_WR;
                    level_q  <= level_q + ONE;
                end
                RD_ISSUE: begin
                    rd_gnt_q <= rd_onehot;
                    rptr     <= rptr_nxt;
                    last_cls <= CLS_RD;
                    level_q  <= level_q - ONE;
                end
                default: ;
            endcase
            if (mismatch)
                err_q <= 1'b1;
        end
    end

    assign bus.wr     = (state == WR_ISSUE);
    assign bus.rd     = (state == RD_ISSUE);
    assign bus.wr_gnt = wr_gnt_q;
    assign bus.rd_gnt = rd_gnt_q;
    assign bus.level  = level_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Scoreboard bench for fifo_port_arbiter with DEPTH=4 and a behavioural FIFO
// counter supplying emp/full.
module tb_fifo_port_arbiter;

    localparam int ADDR_W = 2;
    localparam int NW     = 4;
    localparam int NR     = 4;
    localparam int DEPTH  = 4;

    typedef struct {
        bit       is_wr;
        logic [3:0] gnt;
        logic [2:0] level;
    } exp_t;

    logic clk;
    logic rst_n;
    logic force_emp0;
    int   fifo_cnt;
    int   checks;
    int   errors;
    exp_t sb[$];

    fifo_port_arbiter_if #(.ADDR_W(ADDR_W), .NW(NW), .NR(NR)) bus ();

    fifo_port_arbiter #(.ADDR_W(ADDR_W), .NW(NW), .NR(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFO occupancy driven by the arbiter's strobes.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) fifo_cnt <= 0;
        else        fifo_cnt <= fifo_cnt + int'(bus.wr) - int'(bus.rd);
    end
    assign bus.emp  = force_emp0 ? 1'b0 : (fifo_cnt == 0);
    assign bus.full = (fifo_cnt == DEPTH);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_op(input bit is_wr, input logic [3:0] gnt, input logic [2:0] lvl);
        exp_t e;
        e.is_wr = is_wr;
        e.gnt   = gnt;
        e.level = lvl;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr"},     bus.wr,     0);
        check({tag, "_rd"},     bus.rd,     0);
        check({tag, "_wr_gnt"}, bus.wr_gnt, 0);
        check({tag, "_rd_gnt"}, bus.rd_gnt, 0);
        check({tag, "_level"},  bus.level,  0);
        check({tag, "_err"},    bus.err,    0);
    endtask

    // Monitor: every issued op is matched against the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && (bus.wr || bus.rd)) begin
            check("wr_rd_exclusive", bus.wr & bus.rd, 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_op: wr=%0b rd=%0b level=%0d with nothing expected",
                         bus.wr, bus.rd, bus.level);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("op_class", bus.wr, e.is_wr);
                check("op_grants", {bus.wr_gnt, bus.rd_gnt},
                      e.is_wr ? {e.gnt, 4'b0000} : {4'b0000, e.gnt});
                check("op_level", bus.level, e.level);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        force_emp0 = 1'b0;
        bus.wr_req = '0;
        bus.rd_req = '0;
        rst_n      = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        step(1);

        // Fill from empty with a single writer: four writes, then stall at full.
        for (int i = 1; i <= 4; i++) expect_op(1'b1, 4'b0001, 3'(i));
        bus.wr_req = 4'b0001;
        step(6);
        bus.wr_req = '0;
        check("fill_stall_wr", bus.wr, 0);
        check("fill_level", bus.level, 4);
        check("fill_err", bus.err, 0);

        // Drain with a single reader down to empty.
        for (int i = 3; i >= 0; i--) expect_op(1'b0, 4'b0010, 3'(i));
        bus.rd_req = 4'b0010;
        step(5);
        bus.rd_req = '0;
        check("drain_stall_rd", bus.rd, 0);
        check("drain_level", bus.level, 0);

        // Fresh reset so the write pointer starts at 0 again.
        rst_n = 1'b0;
        #1 check("rst2_level", bus.level, 0);
        @(negedge clk) rst_n = 1'b1;
        step(1);

        // All writers requesting: round-robin order 0,1,2,3.
        expect_op(1'b1, 4'b0001, 3'd1);
        expect_op(1'b1, 4'b0010, 3'd2);
        expect_op(1'b1, 4'b0100, 3'd3);
        expect_op(1'b1, 4'b1000, 3'd4);
        bus.wr_req = 4'b1111;
        step(4);
        bus.wr_req = '0;

        // Two reads bring the level to 2 (last class is now read).
        expect_op(1'b0, 4'b0001, 3'd3);
        expect_op(1'b0, 4'b0001, 3'd2);
        bus.rd_req = 4'b0001;
        step(2);
        bus.rd_req = '0;

        // Both classes eligible: strict alternation starting with a write.
        expect_op(1'b1, 4'b0001, 3'd3);
        expect_op(1'b0, 4'b0001, 3'd2);
        expect_op(1'b1, 4'b0001, 3'd3);
        expect_op(1'b0, 4'b0001, 3'd2);
        bus.wr_req = 4'b0001;
        bus.rd_req = 4'b0001;
        step(4);
        bus.wr_req = '0;
        bus.rd_req = '0;
        check("alt_level", bus.level, 2);

        // Drain to empty before the flag-consistency test.
        expect_op(1'b0, 4'b0001, 3'd1);
        expect_op(1'b0, 4'b0001, 3'd0);
        bus.rd_req = 4'b0001;
        step(2);
        bus.rd_req = '0;
        step(1);
        check("pre_force_err", bus.err, 0);

        // emp forced low while committed occupancy is 0: err must set and stick.
        force_emp0 = 1'b1;
        step(1);
        check("err_rise", bus.err, 1);
        force_emp0 = 1'b0;
        step(3);
        check("err_sticky", bus.err, 1);

        // Reset in the middle of a write burst at level 3.
        expect_op(1'b1, 4'b0001, 3'd1);
        expect_op(1'b1, 4'b0001, 3'd2);
        expect_op(1'b1, 4'b0001, 3'd3);
        bus.wr_req = 4'b0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("burst_level_before_rst", bus.level, 3);
        rst_n      = 1'b0;
        bus.wr_req = '0;
        #1 check_all_zero("mid_rst");
        @(negedge clk) rst_n = 1'b1;
        step(1);

        // Contention from empty after reset: write first, then read.
        expect_op(1'b1, 4'b0001, 3'd1);
        expect_op(1'b0, 4'b0001, 3'd0);
        bus.wr_req = 4'b0001;
        bus.rd_req = 4'b0001;
        step(2);
        bus.wr_req = '0;
        bus.rd_req = '0;
        step(3);
        check("final_err", bus.err, 0);
        check("final_level", bus.level, 0);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_port_arbiter.md
# fifo_port_arbiter

Issue controller for the shared FIFO pointer block: arbitrates NW write requesters and NR read requesters onto the FIFO's single `wr`/`rd` strobe pair. It guarantees `wr` and `rd` are never high in the same cycle. It never issues a write when full or a read when empty, using its own registered occupancy count. It cross-checks that count against the FIFO's `emp`/`full` flags. It sits directly in front of the FIFO, with `wr`/`rd` driving its inputs.

## Interface
- `ADDR_W`, 5: FIFO address width; DEPTH = 2**ADDR_W.
- `NW`, 4: number of write requesters, at least 1.
- `NR`, 4: number of read requesters, at least 1.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_req`  in  NW  per-writer request level; held until granted.
- `rd_req`  in  NR  per-reader request level; held until granted.
- `emp`  in  1  FIFO empty flag; used only for the consistency check.
- `full`  in  1  FIFO full flag; used only for the consistency check.
- `wr`  out  1  registered write strobe to the FIFO.
- `rd`  out  1  registered read strobe to the FIFO.
- `wr_gnt`  out  NW  registered one-hot write grant, coincident with `wr`.
- `rd_gnt`  out  NR  registered one-hot read grant, coincident with `rd`.
- `level`  out  ADDR_W+1  occupancy, including the op currently on `wr`/`rd`.
- `err`  out  1  sticky consistency-error flag.

## Operation
- States:
  - IDLE: no op issued this cycle.
  - WR_ISSUE: `wr`=1.
  - RD_ISSUE: `rd`=1.
- One issue slot per cycle. Next state is decided combinationally from the registered state and the sampled requests.
- Eligibility:
  - Write class is eligible when `|wr_req` and `level` < DEPTH.
  - Read class is eligible when `|rd_req` and `level` > 0.
- Class choice:
  - If only one class is eligible, that class is issued.
  - If both are eligible, the class opposite to `last_cls` is issued.
  - `last_cls` is a 1-bit register updated on every issue; it holds through IDLE.
  - If neither class is eligible, the next state is IDLE.
- Within a class, round-robin:
  - Each class has its own pointer `wptr`/`rptr`.
  - The search starts at the pointer index and wraps modulo NW or NR.
  - After granting index i, the pointer becomes (i+1) mod N.
  - A non-issuing class keeps its pointer unchanged.
- Occupancy update at the same edge the op is registered:
  - `level` +1 when entering WR_ISSUE.
  - `level` −1 when entering RD_ISSUE.
  - No other `level` updates; it never exceeds DEPTH or goes below 0.
- Consistency check:
  - committed = `level` − `wr` + `rd` (the FIFO's view, one cycle behind).
  - `err` sets when `emp` ≠ (committed==0) or `full` ≠ (committed==DEPTH).
  - `err` stays set until reset.
- Requesters: a requester with `gnt` high this cycle must drop or re-present its request on the next cycle. A request still high after a grant is treated as a new request.
- Reset (async, any time, including mid-issue):
  - `wr`, `rd`, `wr_gnt`, `rd_gnt`, `level`, `err` = 0.
  - `wptr` = `rptr` = 0.
  - State = IDLE; `last_cls` = RD, so a write wins the first contention.

## Timing
- Requests sampled at edge k; the resulting `wr`/`rd` and its grant are valid for the whole cycle after edge k. Latency is 1 cycle.
- `gnt` is a single-cycle pulse per issued op.
- Sustained throughput is 1 op per cycle:
  - Back-to-back writes are allowed up to DEPTH.
  - Back-to-back reads are allowed down to empty.
- With both classes continuously eligible, issues alternate WR, RD, WR, RD…
- With `level`=DEPTH and only writes pending: IDLE until a read issues, then the write goes on the following cycle if still eligible.
- With `level`=0 and both requesting: the write issues first, and the read issues the next cycle (`level` is now 1).
- `err` rises one cycle after the sampled mismatch.

## Test plan
- Reset, then `wr_req`=0001 held for 6 cycles with ADDR_W=2:
  - `wr`=1 for 4 consecutive cycles.
  - `level` goes 1,2,3,4, then `wr`=0 while `level`=4.
  - `err`=0 against a real FIFO.
- Full FIFO (`level`=4), then `rd_req`=0010 held for 5 cycles: `rd_gnt`=0010 for 4 cycles, `level` goes 3,2,1,0, then IDLE.
- `wr_req`=1111 held for 4 cycles, `level` starting at 0 → `wr_gnt` sequence 0001, 0010, 0100, 1000.
- `level`=2, `wr_req`=0001 and `rd_req`=0001 both held → alternation WR,RD,WR,RD from `last_cls`.
  - `wr`&`rd` never both 1.
  - `level` toggles 3,2,3,2.
- Force `emp`=0 while committed occupancy is 0 → `err`=1 the next cycle and stays 1 after the stimulus is removed.
- Assert `rst_n`=0 mid-burst with `level`=3 → all outputs 0 immediately. After release, the first contention grants a write.
